gp_serial_sum_resolver: RTL and testbench

//  Consumer end of the generate/propagate interface driven by the per-bit G/P cells.

---
 rtl/gp_serial_sum_resolver.sv | 195 +++++++++++++++++++
 tb/tb_gp_serial_sum_resolver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gp_serial_sum_resolver.sv
// gp_serial_sum_resolver
//   Consumes a digit-serial stream of W-bit generate/propagate beats (LSB beat
//   first), resolves carries inside each beat with a Kogge-Stone prefix tree,
//   chains the carry between beats in carry_r and emits sum digits S = P ^ C.
//   Framing errors (missing or unexpected first beat) are recovered by treating
//   the beat as a fresh first beat, and they raise a sticky err flag.
//
// Optional build macro: GP_RESOLVER_PIPE_EN
//   Defined:   a register stage sits between the prefix tree and the sum XOR.
//              Latency is 2 cycles. The inter-beat carry still closes in one
//              cycle, so throughput stays at 1 beat/cycle.
//   Undefined: single-stage datapath with 1 cycle latency.

module gp_serial_sum_resolver #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_g,
  input  logic [W-1:0] in_p,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         err
);

  localparam int LV = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic                  accept_s;
  logic                  restart_s;
  logic                  frame_err_s;
  logic                  c0_s;
  logic [W:0]            c_s;
  logic [LV:0][W-1:0]    gg_s;
  logic [LV:0][W-1:0]    pp_s;
  logic                  carry_r;
  logic                  err_r;
  logic                  out_valid_r;
  logic [W-1:0]          out_sum_r;
  logic                  out_last_r;
  logic                  out_cout_r;

  // The output register can take a new value when empty or being drained.
  assign in_ready  = ~out_valid_r | out_ready;
  assign accept_s  = in_valid & in_ready;

  // A beat starts a new operand when flagged first, or when nothing is open.
  assign restart_s   = in_first | (state_r == IDLE);
  assign frame_err_s = accept_s & (((state_r == IDLE) & ~in_first) |
                                   ((state_r == ACTIVE) & in_first));
  assign c0_s        = restart_s ? cin : carry_r;

  // Kogge-Stone prefix: level l combines each bit with the group 2^l below it.
  always_comb begin
    gg_s    = '0;
    pp_s    = '0;
    gg_s[0] = in_g;
    pp_s[0] = in_p;
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (32'sd1 <<< l)) begin
          gg_s[l+1][i] = gg_s[l][i] | (pp_s[l][i] & gg_s[l][i - (32'sd1 <<< l)]);
          pp_s[l+1][i] = pp_s[l][i] & pp_s[l][i - (32'sd1 <<< l)];
        end else begin
          gg_s[l+1][i] = gg_s[l][i];
          pp_s[l+1][i] = pp_s[l][i];
        end
      end
    end
  end

  // Final gray cells fold the beat carry-in into every group prefix.
  always_comb begin
    c_s    = '0;
    c_s[0] = c0_s;
    for (int i = 0; i < W; i++) begin
      c_s[i+1] = gg_s[LV][i] | (pp_s[LV][i] & c0_s);
    end
  end

  // Framing FSM next state: any accepted last beat closes the operand.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, ACTIVE: begin
        if (accept_s) begin
          state_nxt_s = in_last ? IDLE : ACTIVE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Framing state, inter-beat carry and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        carry_r <= in_last ? 1'b0 : c_s[W];
      end
      if (frame_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef GP_RESOLVER_PIPE_EN
  logic         s1_valid_r;
  logic [W-1:0] s1_p_r;
  logic [W-1:0] s1_c_r;
  logic         s1_last_r;
  logic         s1_cout_r;

  // Stage 1 captures the resolved carries; it moves whenever stage 2 can accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_p_r     <= '0;
      s1_c_r     <= '0;
      s1_last_r  <= 1'b0;
      s1_cout_r  <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_p_r    <= in_p;
        s1_c_r    <= c_s[W-1:0];
        s1_last_r <= in_last;
        s1_cout_r <= in_last ? c_s[W] : 1'b0;
      end
    end
  end

  // Stage 2 applies the sum XOR and holds the digit until downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_last_r  <= 1'b0;
      out_cout_r  <= 1'b0;
    end else if (in_ready) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_sum_r  <= s1_p_r ^ s1_c_r;
        out_last_r <= s1_last_r;
        out_cout_r <= s1_cout_r;
      end
    end
  end
`else
  // Single output register: reload on accept, otherwise drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_last_r  <= 1'b0;
      out_cout_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= in_p ^ c_s[W-1:0];
      out_last_r  <= in_last;
      out_cout_r  <= in_last ? c_s[W] : 1'b0;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_last  = out_last_r;
  assign out_cout  = out_cout_r;
  assign err       = err_r;

endmodule

// File: tb/tb_gp_serial_sum_resolver.sv
// Self-checking bench for gp_serial_sum_resolver (W=4, default single-stage build).
// The reference model works on whole-digit arithmetic: a beat with generate g and
// propagate p represents a+b = 2*g + p, so the digit result is 2*g + p + carry-in.

module tb_gp_serial_sum_resolver;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_g;
  logic [W-1:0] in_p;
  logic         in_first;
  logic         in_last;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         err;

  int n_vec;
  int n_bad;

  // Reference model state
  bit         m_active;
  bit         m_carry;
  bit         m_err;
  bit         m_valid;
  bit [W-1:0] m_sum;
  bit         m_last;
  bit         m_cout;

  gp_serial_sum_resolver #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_g      (in_g),
    .in_p      (in_p),
    .in_first  (in_first),
    .in_last   (in_last),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_carry  = 1'b0;
    m_err    = 1'b0;
    m_valid  = 1'b0;
    m_sum    = '0;
    m_last   = 1'b0;
    m_cout   = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle(output bit acc);
    bit pop;
    bit c0;
    int tot;
    @(negedge clk);
    chk("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
    chk("in_ready", {7'd0, in_ready}, {7'd0, (~m_valid | out_ready)});
    chk("err", {7'd0, err}, {7'd0, m_err});
    if (m_valid) begin
      chk("out_sum", {4'd0, out_sum}, {4'd0, m_sum});
      chk("out_last", {7'd0, out_last}, {7'd0, m_last});
      chk("out_cout", {7'd0, out_cout}, {7'd0, m_cout});
    end
    acc = in_valid & (~m_valid | out_ready);
    pop = m_valid & out_ready;
    if (acc) begin
      if ((!m_active && !in_first) || (m_active && in_first)) m_err = 1'b1;
      c0      = (in_first || !m_active) ? cin : m_carry;
      tot     = 2 * int'(in_g) + int'(in_p) + int'(c0);
      m_sum   = tot[W-1:0];
      m_last  = in_last;
      m_cout  = in_last ? tot[W] : 1'b0;
      m_carry = in_last ? 1'b0 : tot[W];
      m_active = !in_last;
      m_valid = 1'b1;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input bit f, input bit l, input logic [3:0] g,
                          input logic [3:0] p, input bit c);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_g     = g;
    in_p     = p;
    cin      = c;
  endtask

  // Present a beat and hold it until it is accepted (bounded).
  task automatic beat(input bit f, input bit l, input logic [3:0] g,
                      input logic [3:0] p, input bit c);
    bit acc;
    int tries;
    set_beat(f, l, g, p, c);
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 20) begin
      cycle(acc);
      tries++;
    end
    if (!acc) begin
      n_vec++;
      n_bad++;
      $error("FAIL beat_timeout: observed 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    bit         acc;
    logic [3:0] a;
    logic [3:0] b;
    bit         open;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_g = 4'h0; in_p = 4'h0; cin = 1'b0; out_ready = 1'b1;
    model_reset();

    // Reset state
    #12;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_sum", {4'd0, out_sum}, 8'd0);
    chk("rst_out_last", {7'd0, out_last}, 8'd0);
    chk("rst_out_cout", {7'd0, out_cout}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single-beat 0x3 + 0x5
    beat(1'b1, 1'b1, 4'h1, 4'h6, 1'b0);
    idle(1);

    // 2: 0xFF + 0x01 over two beats
    beat(1'b1, 1'b0, 4'h1, 4'hE, 1'b0);
    beat(1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
    idle(1);

    // 3: same frame with out_ready low for 3 cycles
    out_ready = 1'b0;
    set_beat(1'b1, 1'b0, 4'h1, 4'hE, 1'b0);
    cycle(acc);
    set_beat(1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
    cycle(acc);
    cycle(acc);
    out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    idle(2);

    // 4: back-to-back frames, frame 2 carries only cin
    beat(1'b1, 1'b0, 4'h1, 4'hE, 1'b0);
    beat(1'b0, 1'b1, 4'h0, 4'hF, 1'b0);
    beat(1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
    idle(1);

    // 5: first beat while a frame is open -> sticky err
    beat(1'b1, 1'b0, 4'h3, 4'h4, 1'b1);
    beat(1'b1, 1'b1, 4'h0, 4'h1, 1'b0);
    idle(10);

    // 6: reset mid-frame
    beat(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_err", {7'd0, err}, 8'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
    idle(1);

    // Randomized framing and back-pressure
    open = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      if (($urandom_range(0, 3) != 0) || !in_valid) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_g     = a & b;
        in_p     = a ^ b;
        cin      = 1'($urandom_range(0, 1));
        in_first = ($urandom_range(0, 19) == 0) ? open : !open;
        in_last  = ($urandom_range(0, 2) == 0);
      end
      cycle(acc);
      if (acc) begin
        open = !in_last;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
